// File: rtl/line_fill_reader_pkg.sv
// Shared types and constants for the line fill reader.
package line_fill_reader_pkg;

  localparam int unsigned DEF_DW           = 16;
  localparam int unsigned DEF_AW           = 16;
  localparam int unsigned DEF_WORDS        = 4;
  localparam int unsigned DEF_LAT          = 2;
  localparam int unsigned WORD_BYTES       = 2;
  localparam int unsigned LINE_OFFSET_BITS = 4;

  function automatic int unsigned idxWidth(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

  localparam int unsigned IDX_W = idxWidth(DEF_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} lfrState_e;

endpackage

// File: rtl/line_fill_reader_if.sv
// Request/response bus between the line fill reader and the banked data memory.
interface line_fill_reader_if
  import line_fill_reader_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) ();

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_stall;
  logic [DW-1:0] mem_data_out;

  modport master (output mem_addr, mem_rd, input mem_stall, mem_data_out);
  modport slave  (input mem_addr, mem_rd, output mem_stall, mem_data_out);

endinterface

// File: rtl/line_fill_reader_rd_inflight_pipe.sv
// LAT-deep {valid,idx} tracker; the tail marks the cycle mem_data_out carries that word.
module rd_inflight_pipe
  import line_fill_reader_pkg::*;
#(
  parameter int unsigned LAT = DEF_LAT,
  parameter int unsigned IW  = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inValid,
  input  logic [IW-1:0] inIdx,
  output logic          outValid,
  output logic [IW-1:0] outIdx
);

  logic [LAT-1:0] stageValid;
  logic [IW-1:0]  stageIdx [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid <= '0;
      for (int i = 0; i < int'(LAT); i++) stageIdx[i] <= '0;
    end else begin
      stageValid[0] <= inValid;
      stageIdx[0]   <= inIdx;
      for (int i = 1; i < int'(LAT); i++) begin
        stageValid[i] <= stageValid[i-1];
        stageIdx[i]   <= stageIdx[i-1];
      end
    end
  end

  assign outValid = stageValid[LAT-1];
  assign outIdx   = stageIdx[LAT-1];

endmodule

// File: rtl/line_fill_reader.sv
// Fetches one cache line from banked memory word by word and returns each word with its index.
// Optional critical-word-first ordering: define LINE_FILL_CRIT_WORD_EN.
module line_fill_reader
  import line_fill_reader_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned WORDS = DEF_WORDS,
  parameter int unsigned LAT   = DEF_LAT,
  localparam int unsigned IW   = idxWidth(WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  line_fill_reader_if.master  mem,
  output logic [DW-1:0]       word_data,
  output logic [IW-1:0]       word_idx,
  output logic                word_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LW = AW - LINE_OFFSET_BITS;

  lfrState_e     state;
  logic [LW-1:0] line;
  logic [IW-1:0] issueIdx;
  logic [IW-1:0] issueCnt;
  logic [IW-1:0] retCnt;
  logic [IW-1:0] firstIdx;
  logic [IW-1:0] tailIdx;
  logic          tailValid;
  logic          accept;

  wire unusedBits = ^base_addr[LINE_OFFSET_BITS-1:0];

`ifdef LINE_FILL_CRIT_WORD_EN
  assign firstIdx = IW'(base_addr[3:1]);
`else
  assign firstIdx = '0;
`endif

  assign accept = mem.mem_rd & ~mem.mem_stall;

  // Offset stays inside the line so the address never carries into the line bits.
  function automatic logic [AW-1:0] wordAddr(input logic [LW-1:0] l, input logic [IW-1:0] i);
    return {l, LINE_OFFSET_BITS'(i) * LINE_OFFSET_BITS'(WORD_BYTES)};
  endfunction

  rd_inflight_pipe #(.LAT(LAT), .IW(IW)) uPipe (
    .clk      (clk),
    .rst      (rst),
    .inValid  (accept),
    .inIdx    (issueIdx),
    .outValid (tailValid),
    .outIdx   (tailIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      line         <= '0;
      issueIdx     <= '0;
      issueCnt     <= '0;
      retCnt       <= '0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      word_data    <= '0;
      word_idx     <= '0;
      word_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      done       <= 1'b0;

      // Capture returning data; the return counter marks the final word of the line.
      if (tailValid) begin
        word_valid <= 1'b1;
        word_data  <= mem.mem_data_out;
        word_idx   <= tailIdx;
        retCnt     <= retCnt + 1'b1;
        if (retCnt == IW'(WORDS - 1)) done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            line         <= base_addr[AW-1:LINE_OFFSET_BITS];
            issueIdx     <= firstIdx;
            issueCnt     <= '0;
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= wordAddr(base_addr[AW-1:LINE_OFFSET_BITS], firstIdx);
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem.mem_stall) begin
            issueIdx <= issueIdx + 1'b1;
            issueCnt <= issueCnt + 1'b1;
            if (issueCnt == IW'(WORDS - 1)) begin
              mem.mem_rd   <= 1'b0;
              mem.mem_addr <= '0;
              state        <= DRAIN;
            end else begin
              mem.mem_addr <= wordAddr(line, issueIdx + 1'b1);
            end
          end
        end
        DRAIN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_reader.sv
// Randomized scoreboard bench for line_fill_reader with a behavioural memory and line model.
module tb_line_fill_reader;
  import line_fill_reader_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned IW    = IDX_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] word_data;
  logic [IW-1:0] word_idx;
  logic          word_valid;
  logic          busy;
  logic          done;

  line_fill_reader_if #(.DW(DW), .AW(AW)) memBus ();

  line_fill_reader #(.DW(DW), .AW(AW), .WORDS(WORDS), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mem        (memBus),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return DW'(a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // Memory: an accepted request's data appears on mem_data_out LAT cycles later, garbage otherwise.
  logic [DW-1:0] memPipe [LAT];
  always @(posedge clk) begin
    for (int i = int'(LAT) - 1; i > 0; i--) memPipe[i] <= memPipe[i-1];
    memPipe[0] <= (memBus.mem_rd && !memBus.mem_stall) ? memWord(memBus.mem_addr) : DW'($urandom);
  end
  assign memBus.mem_data_out = memPipe[LAT-1];

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    bit            last;
  } expWord_t;

  expWord_t      wordQ [$];
  logic [AW-1:0] addrQ [$];
  int            retQ  [$];
  int            expFirstReq = -1;
  int            expBusyAt   = -1;
  int            expIdleAt   = -1;
  bit            fetchDone   = 1'b0;

  // Line model: request order starts at the critical word (or 0) and wraps within the line.
  task automatic pushExpect(input logic [AW-1:0] ba);
    logic [IW-1:0] crit;
    logic [IW-1:0] i;
    logic [AW-1:0] a;
`ifdef LINE_FILL_CRIT_WORD_EN
    crit = IW'(ba[3:1]);
`else
    crit = '0;
`endif
    for (int k = 0; k < int'(WORDS); k++) begin
      i = IW'(int'(crit) + k);
      a = {ba[AW-1:4], 4'(int'(i) * 2)};
      addrQ.push_back(a);
      wordQ.push_back('{idx: i, data: memWord(a), last: (k == int'(WORDS) - 1)});
    end
    expFirstReq = cycle + 1;
    expBusyAt   = cycle + 1;
    fetchDone   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (memBus.mem_rd) begin
        if (addrQ.size() == 0) begin
          check(1'b0, "spurious_rd", 32'(memBus.mem_addr), 32'(0));
        end else begin
          check(memBus.mem_addr == addrQ[0], "mem_addr", 32'(memBus.mem_addr), 32'(addrQ[0]));
          if (!memBus.mem_stall) begin
            void'(addrQ.pop_front());
            retQ.push_back(cycle + int'(LAT) + 1);
          end
        end
      end else begin
        check(memBus.mem_addr == '0, "idle_addr", 32'(memBus.mem_addr), 32'(0));
      end

      if (word_valid) begin
        if (wordQ.size() == 0) begin
          check(1'b0, "extra_word", 32'(word_idx), 32'(0));
        end else begin
          expWord_t e;
          int r;
          e = wordQ.pop_front();
          r = (retQ.size() != 0) ? retQ.pop_front() : -1;
          check(word_idx == e.idx, "word_idx", 32'(word_idx), 32'(e.idx));
          check(word_data == e.data, "word_data", 32'(word_data), 32'(e.data));
          check(done == e.last, "done", 32'(done), 32'(e.last));
          check(cycle == r, "word_cycle", 32'(cycle), 32'(r));
          if (e.last) begin
            fetchDone = 1'b1;
            expIdleAt = cycle + 1;
          end
        end
      end else if (done) begin
        check(1'b0, "done_without_word", 32'(done), 32'(0));
      end

      if (cycle == expFirstReq) check(memBus.mem_rd == 1'b1, "first_req", 32'(memBus.mem_rd), 32'(1));
      if (cycle == expBusyAt)   check(busy == 1'b1, "busy_set", 32'(busy), 32'(1));
      if (cycle == expIdleAt)   check(busy == 1'b0, "busy_clear", 32'(busy), 32'(0));
    end
  end

  task automatic checkAllZero(input string tag);
    check(word_valid == 1'b0,      {tag, "_word_valid"}, 32'(word_valid), 32'(0));
    check(done == 1'b0,            {tag, "_done"},       32'(done), 32'(0));
    check(busy == 1'b0,            {tag, "_busy"},       32'(busy), 32'(0));
    check(memBus.mem_rd == 1'b0,   {tag, "_mem_rd"},     32'(memBus.mem_rd), 32'(0));
    check(memBus.mem_addr == '0,   {tag, "_mem_addr"},   32'(memBus.mem_addr), 32'(0));
    check(word_data == '0,         {tag, "_word_data"},  32'(word_data), 32'(0));
    check(word_idx == '0,          {tag, "_word_idx"},   32'(word_idx), 32'(0));
  endtask

  // Issue one fetch, then drive random stalls and stray starts until the line completes.
  task automatic issueFetch(input logic [AW-1:0] ba, input int stallPct, input bit stray);
    int n;
    pushExpect(ba);
    start     = 1'b1;
    base_addr = ba;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!fetchDone && n < 200) begin
      memBus.mem_stall = ($urandom_range(0, 99) < stallPct);
      start            = stray && ($urandom_range(0, 3) == 0);
      base_addr        = AW'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    if (!fetchDone) check(1'b0, "fetch_timeout", 32'(n), 32'(0));
    memBus.mem_stall = 1'b0;
  endtask

  task automatic resetMidFetch(input logic [AW-1:0] ba, input int runCycles);
    pushExpect(ba);
    start     = 1'b1;
    base_addr = ba;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (runCycles) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    wordQ.delete();
    addrQ.delete();
    retQ.delete();
    expFirstReq = -1;
    expBusyAt   = -1;
    expIdleAt   = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check(busy == 1'b0, "post_reset_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d cycles", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    memBus.mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    issueFetch(16'h0040, 0, 1'b0);
    issueFetch(16'h0126, 0, 1'b0);
    issueFetch(16'hFFFE, 0, 1'b1);
    issueFetch(16'h0040, 40, 1'b1);
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issueFetch(AW'($urandom), int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 3; n++) begin
      resetMidFetch(AW'($urandom), int'($urandom_range(1, 7)));
      issueFetch(AW'($urandom), int'($urandom_range(0, 40)), 1'b1);
    end

    repeat (6) begin @(posedge clk); #1; end
    check(wordQ.size() == 0, "words_outstanding", 32'(wordQ.size()), 32'(0));
    check(addrQ.size() == 0, "reqs_outstanding", 32'(addrQ.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/line_fill_reader.md
Name: line_fill_reader

Overview:
- Read-side controller for the four-bank data memory; the reader counterpart of the write-enabled register storage path.
- On a start pulse, fetches one 4-word (8-byte) cache line and returns each word with its index, then pulses done.
- Sits between the cache-miss FSM and the banked memory.
- Tolerates memory stalls and a fixed read latency.

Parameters:
- DW, 16: data word width.
- AW, 16: byte address width.
- WORDS, 4: words per line; power of two, at least 2.
- LAT, 2: cycles from an accepted request to data on mem_data_out; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a line fetch; sampled only when busy=0.
- base_addr  in  AW  line address; bits [3:1] give the critical word (see Optional Feature); bits [3:0] are otherwise ignored.
- mem_addr  out  AW  word byte-address of the current request.
- mem_rd  out  1  read request.
- mem_stall  in  1  memory refuses this cycle's request.
- mem_data_out  in  DW  memory read data.
- word_data  out  DW  returned word, registered.
- word_idx  out  log2(WORDS)  line index of word_data.
- word_valid  out  1  word_data/word_idx valid this cycle.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse with the last word_valid.

Behaviour:
- Reset, asynchronous: every output is 0. FSM=IDLE. Issue counter, return counter and in-flight tracker are cleared. Reset mid-fetch aborts it; data still returning from memory is discarded and no word_valid is produced for it.
- States:
  - IDLE: start=1 latches base_addr[AW-1:4] and moves to ISSUE. busy=1 from the next cycle.
  - ISSUE: mem_rd=1, mem_addr={line,idx,1'b0}. A request is accepted when mem_rd & ~mem_stall. On acceptance idx advances; after WORDS acceptances go to DRAIN.
  - DRAIN: mem_rd=0. Once all WORDS words have returned, go to IDLE.
- mem_addr while stalled: held at the same value.
- In-flight tracker: LAT-deep shift register of {valid,idx}. Word index k accepted at the edge ending cycle t is read from mem_data_out during cycle t+LAT. It is registered, so word_valid=1 with word_idx=k in cycle t+LAT+1.
- done: asserted in the same cycle as the WORDS-th word_valid. busy is 1 in that cycle and 0 the next. A start is accepted no earlier than the cycle after done.
- start while busy=1: ignored, with no queuing.
- Outputs in idle: mem_addr=0 whenever mem_rd=0; word_data holds its last value when word_valid=0.
- mem_stall while mem_rd=0: ignored.
- Index arithmetic: the index counter wraps modulo WORDS. The address never carries into base_addr[AW-1:4].

Optional Feature:
- Macro: LINE_FILL_CRIT_WORD_EN.
- Defined: the first request uses index base_addr[3:1] (truncated to log2(WORDS) bits), then increments with wrap. For example, crit=2 gives order 2,3,0,1.
- Undefined: order is always 0,1,2,3 and base_addr[3:1] is ignored.
- In both builds, word_idx always reports the true line index.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, ISSUE, DRAIN}.
  - WORD_BYTES=2.
  - LINE_OFFSET_BITS=4.
  - Index-width constant, derived as clog2(WORDS).
- Sub-module rd_inflight_pipe: LAT-stage {valid,idx} shift register with asynchronous reset. Input is the accept pulse plus idx; output is the tail valid/idx used to capture mem_data_out.

Test Plan:
- Basic fetch: start with base_addr=0x0040 in cycle 0, no stalls, memory returns 0xA000+addr.
  - mem_addr = 0x40, 0x42, 0x44, 0x46 in cycles 1-4.
  - word_valid in cycles 4-7 with idx 0-3 and data 0xA040-0xA046.
  - done in cycle 7; busy=0 in cycle 8.
- Stall: mem_stall=1 in cycles 2-3 (while word 1 is requested).
  - mem_addr holds 0x42 through cycle 4.
  - Everything after shifts by 2 cycles; done in cycle 9.
  - No duplicate or missing word indices.
- start while busy: start pulsed again in cycle 3.
  - Ignored; exactly 4 word_valid and 1 done.
  - A new start in cycle 8 begins a fresh fetch.
- Reset mid-fetch: rst asserted in cycle 5, released in cycle 6.
  - All outputs 0 immediately.
  - No word_valid afterwards even though memory still drives data.
  - FSM is in IDLE.
- With LINE_FILL_CRIT_WORD_EN, base_addr=0x0126 (crit=3):
  - Request order 0x126, 0x120, 0x122, 0x124.
  - word_idx order 3,0,1,2; done with idx 2.
  - Without the macro: order 0x120-0x126.
